fetch_stall_ctrl: RTL and testbench

Fetch-side consumer of the hazard unit's `stall` signal. It holds the PC register and the IF/ID pipeline register, and applies the pipeline's three per-cycle outcomes: stall (freeze and bubble), branch redirect (flush), and normal advance. It sits between instruction memory and the decode stage. It also keeps stall/flush performance counters and a consecutive-stall watchdog.

---
 rtl/fetch_stall_ctrl.sv | 118 +++++++++++
 tb/tb_fetch_stall_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stall_ctrl.sv
// Fetch-stage PC and IF/ID register control. Applies stall, redirect and
// advance in that priority each cycle, and keeps stall/flush counters plus a
// consecutive-stall watchdog.
module fetch_stall_ctrl #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013,
    parameter int unsigned      MAX_STALL = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic            id_ex_bubble,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count,
    output logic            stall_error
);

    localparam logic [3:0]      MaxStall = 4'(MAX_STALL);
    localparam logic [XLEN-1:0] PcStep   = XLEN'(4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [31:0]     stall_count_q, stall_count_d;
    logic [31:0]     flush_count_q, flush_count_d;
    logic [3:0]      run_q, run_d;
    logic            stall_error_q, stall_error_d;

    logic            redirect;

    // Stall wins over a simultaneous branch; the branch re-evaluates later.
    assign redirect = ~stall & branch_taken;

    // PC and IF/ID next state: hold on stall, flush on redirect, else advance.
    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (stall) begin
            pc_d = pc_q;
        end else if (branch_taken) begin
            pc_d          = {branch_target[XLEN-1:2], 2'b00};
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else begin
            pc_d          = pc_q + PcStep;
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
        end
    end

    // Saturating performance counters and the consecutive-stall watchdog.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        run_d         = '0;
        stall_error_d = stall_error_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
        if (redirect && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
        if (stall) begin
            run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;
            // Run reaches MAX_STALL+1 on this edge; compare on the old value so
            // MAX_STALL=15 still trips against the saturated 4-bit run counter.
            if (run_q >= MaxStall) begin
                stall_error_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
            run_q         <= '0;
            stall_error_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
            run_q         <= run_d;
            stall_error_q <= stall_error_d;
        end
    end

    assign pc           = pc_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_valid  = if_id_valid_q;
    assign id_ex_bubble = stall;
    assign stall_count  = stall_count_q;
    assign flush_count  = flush_count_q;
    assign stall_error  = stall_error_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl with hand-computed expectations.
module tb_fetch_stall_ctrl;

    localparam logic [31:0] Pat = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        id_ex_bubble;
    logic [31:0] stall_count;
    logic [31:0] flush_count;
    logic        stall_error;

    int errors = 0;
    int checks = 0;

    fetch_stall_ctrl #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013),
        .MAX_STALL (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .id_ex_bubble  (id_ex_bubble),
        .stall_count   (stall_count),
        .flush_count   (flush_count),
        .stall_error   (stall_error)
    );

    // Instruction memory: PC-derived pattern, combinational read.
    assign imem_rdata = pc ^ Pat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        #1;
        check("rst_pc",     pc, 32'h0);
        check("rst_ifpc",   if_id_pc, 32'h0);
        check("rst_instr",  if_id_instr, 32'h13);
        check("rst_valid",  {31'b0, if_id_valid}, 32'h0);
        check("rst_scnt",   stall_count, 32'h0);
        check("rst_fcnt",   flush_count, 32'h0);
        check("rst_err",    {31'b0, stall_error}, 32'h0);
        stall = 1'b1;
        #1;
        check("rst_bubble", {31'b0, id_ex_bubble}, 32'h1);
        stall = 1'b0;
        #1;
        rst = 1'b0;

        // Free-run three edges.
        step(); step(); step();
        check("run_pc",     pc, 32'hC);
        check("run_ifpc",   if_id_pc, 32'h8);
        check("run_valid",  {31'b0, if_id_valid}, 32'h1);
        check("run_instr",  if_id_instr, 32'h8 ^ Pat);
        check("run_scnt",   stall_count, 32'h0);
        check("run_bubble", {31'b0, id_ex_bubble}, 32'h0);
        step();
        check("run_pc4",    pc, 32'h10);

        // Single load-use stall.
        stall = 1'b1;
        #1;
        check("ls_bubble",  {31'b0, id_ex_bubble}, 32'h1);
        step();
        check("ls_pc",      pc, 32'h10);
        check("ls_ifpc",    if_id_pc, 32'hC);
        check("ls_instr",   if_id_instr, 32'hC ^ Pat);
        check("ls_scnt",    stall_count, 32'h1);
        stall = 1'b0;
        step();
        check("ls_pc_adv",  pc, 32'h14);
        check("ls_ifpc_adv", if_id_pc, 32'h10);

        // Stall with simultaneous branch for two cycles, then release stall.
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        #1;
        check("sb_bubble",  {31'b0, id_ex_bubble}, 32'h1);
        step();
        check("sb_pc1",     pc, 32'h14);
        step();
        check("sb_pc2",     pc, 32'h14);
        check("sb_ifpc",    if_id_pc, 32'h10);
        check("sb_valid",   {31'b0, if_id_valid}, 32'h1);
        check("sb_fcnt0",   flush_count, 32'h0);
        check("sb_scnt",    stall_count, 32'h3);
        stall = 1'b0;
        step();
        check("br_pc",      pc, 32'h100);
        check("br_valid",   {31'b0, if_id_valid}, 32'h0);
        check("br_instr",   if_id_instr, 32'h13);
        check("br_ifpc",    if_id_pc, 32'h0);
        check("br_fcnt",    flush_count, 32'h1);
        check("br_err",     {31'b0, stall_error}, 32'h0);
        branch_taken = 1'b0;
        step();
        check("tgt_pc",     pc, 32'h104);
        check("tgt_ifpc",   if_id_pc, 32'h100);
        check("tgt_instr",  if_id_instr, 32'h100 ^ Pat);

        // Misaligned target.
        branch_taken  = 1'b1;
        branch_target = 32'h203;
        step();
        check("mis_pc",     pc, 32'h200);
        check("mis_fcnt",   flush_count, 32'h2);
        branch_taken = 1'b0;

        // Watchdog: three stalls do not trip it.
        stall = 1'b1;
        step(); step(); step();
        check("wd3_err",    {31'b0, stall_error}, 32'h0);
        check("wd3_scnt",   stall_count, 32'h6);
        stall = 1'b0;
        step();
        check("wd3_pc",     pc, 32'h204);
        check("wd3_err2",   {31'b0, stall_error}, 32'h0);

        // Four consecutive stalls trip it; it stays set.
        stall = 1'b1;
        step(); step(); step();
        check("wd4_err_pre", {31'b0, stall_error}, 32'h0);
        step();
        check("wd4_err",    {31'b0, stall_error}, 32'h1);
        check("wd4_scnt",   stall_count, 32'd10);
        stall = 1'b0;
        step();
        check("wd4_sticky", {31'b0, stall_error}, 32'h1);
        check("wd4_pc",     pc, 32'h208);

        // Wrap from the top of the address space.
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        check("wr_pc_top",  pc, 32'hFFFF_FFFC);
        check("wr_fcnt",    flush_count, 32'h3);
        branch_taken = 1'b0;
        step();
        check("wr_pc",      pc, 32'h0);
        check("wr_ifpc",    if_id_pc, 32'hFFFF_FFFC);
        check("wr_sticky",  {31'b0, stall_error}, 32'h1);

        // Asynchronous reset between edges during a stall.
        stall = 1'b1;
        step();
        check("mr_scnt",    stall_count, 32'd11);
        #2;
        rst = 1'b1;
        #1;
        check("mr_pc",      pc, 32'h0);
        check("mr_ifpc",    if_id_pc, 32'h0);
        check("mr_instr",   if_id_instr, 32'h13);
        check("mr_valid",   {31'b0, if_id_valid}, 32'h0);
        check("mr_scnt",    stall_count, 32'h0);
        check("mr_fcnt",    flush_count, 32'h0);
        check("mr_err",     {31'b0, stall_error}, 32'h0);
        check("mr_bubble",  {31'b0, id_ex_bubble}, 32'h1);
        stall = 1'b0;
        #1;
        rst = 1'b0;
        step();
        check("post_pc",    pc, 32'h4);
        check("post_valid", {31'b0, if_id_valid}, 32'h1);
        check("post_instr", if_id_instr, 32'h0 ^ Pat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
